sa_mux_sel_sequencer: RTL and testbench

SA_MUX_SEL_SEQUENCER -- requirements
Module: sa_mux_sel_sequencer

---
 rtl/sa_mux_sel_sequencer.sv | 109 ++++++++++
 tb/tb_sa_mux_sel_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sa_mux_sel_sequencer.sv
// Anti-diagonal position sequencer for an N x N systolic array operand MUX.
// Optional one-hot select output is enabled by defining SA_SEL_ONEHOT_EN.
module sa_mux_sel_sequencer #(
  parameter int N = 3,
  localparam int SW = (N > 2) ? $clog2(N) : 1,
  localparam int CW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  output logic          valid,
  output logic          done,
  output logic [SW-1:0] sel,
  output logic [SW-1:0] col,
`ifdef SA_SEL_ONEHOT_EN
  output logic [N-1:0]  sel_onehot,
`endif
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SW-1:0] LAST   = SW'(N - 1);
  localparam logic [SW:0]   LAST_W = (SW + 1)'(N - 1);

  state_t        state, state_n;
  logic [SW-1:0] sel_n, col_n;
  logic [CW-1:0] cnt_n;
  logic [SW:0]   d_next;
  logic          at_last;

  assign at_last = (sel == LAST) && (col == LAST);

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    col_n   = col;
    cnt_n   = cnt;
    d_next  = {1'b0, sel} + {1'b0, col} + (SW + 1)'(1);
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (step) begin
          if (at_last) begin
            state_n = DONE;
            sel_n   = '0;
            col_n   = '0;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
            if (sel != LAST && col != '0) begin
              sel_n = sel + SW'(1);
              col_n = col - SW'(1);
            end else if (d_next > LAST_W) begin
              // Next diagonal starts on the right edge once it passes the corner.
              sel_n = SW'(d_next - LAST_W);
              col_n = LAST;
            end else begin
              sel_n = '0;
              col_n = SW'(d_next);
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        col_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      done  <= 1'b0;
      sel   <= '0;
      col   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      valid <= (state_n == RUN);
      done  <= (state_n == DONE);
      sel   <= sel_n;
      col   <= col_n;
      cnt   <= cnt_n;
    end
  end

`ifdef SA_SEL_ONEHOT_EN
  always_ff @(posedge clk) begin
    if (reset) sel_onehot <= '0;
    else       sel_onehot <= (state_n == RUN) ? (N'(1) << sel_n) : '0;
  end
`endif

endmodule

// File: tb/tb_sa_mux_sel_sequencer.sv
// Scoreboard bench for sa_mux_sel_sequencer: expected traversal positions are
// queued when a start is accepted and popped as the DUT consumes them.
module tb_sa_mux_sel_sequencer;

  localparam int N  = 3;
  localparam int SW = (N > 2) ? $clog2(N) : 1;
  localparam int CW = $clog2(N * N);

  typedef struct {
    int s;
    int c;
    int n;
  } pos_t;

  logic          clk = 1'b0;
  logic          reset, start, step;
  logic          valid, done;
  logic [SW-1:0] sel, col;
  logic [CW-1:0] cnt;
`ifdef SA_SEL_ONEHOT_EN
  logic [N-1:0]  sel_onehot;
`endif

  sa_mux_sel_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .step  (step),
    .valid (valid),
    .done  (done),
    .sel   (sel),
    .col   (col),
`ifdef SA_SEL_ONEHOT_EN
    .sel_onehot (sel_onehot),
`endif
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  pos_t order[$];
  pos_t exp_q[$];
  int   m_phase  = 0;  // 0 idle, 1 run, 2 done

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: timed out waiting for DUT", name, $time);
  endtask

  function automatic logic [31:0] pack(input int v, input int d, input int s, input int c, input int n);
    return (v << 30) | (d << 29) | (s << 20) | (c << 10) | n;
  endfunction

  // Reference traversal: walk diagonals d = row + col in increasing order,
  // rows ascending within a diagonal.
  initial begin
    for (int d = 0; d <= 2 * N - 2; d++)
      for (int r = 0; r < N; r++) begin
        pos_t p;
        p.s = r;
        p.c = d - r;
        p.n = order.size();
        if (p.c >= 0 && p.c < N) order.push_back(p);
      end
  end

  // Monitor: compare the presented outputs, then advance the model with the
  // inputs the DUT will sample at the coming rising edge.
  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    int          exp_oh;
    if (m_phase == 1) begin
      exp_v  = pack(1, 0, exp_q[0].s, exp_q[0].c, exp_q[0].n);
      exp_oh = 1 << exp_q[0].s;
    end else begin
      exp_v  = pack(0, (m_phase == 2) ? 1 : 0, 0, 0, 0);
      exp_oh = 0;
    end
    act_v = pack(int'(valid), int'(done), int'(sel), int'(col), int'(cnt));
    check("outputs{valid,done,sel,col,cnt}", act_v, exp_v);
`ifdef SA_SEL_ONEHOT_EN
    check("sel_onehot", 32'(sel_onehot), 32'(exp_oh));
`endif
    if (reset) begin
      m_phase = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
             foreach (order[i]) exp_q.push_back(order[i]);
             m_phase = 1;
           end
        1: if (step) begin
             void'(exp_q.pop_front());
             if (exp_q.size() == 0) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 100; i++) begin
      if (valid && int'(cnt) == v) return;
      tick();
    end
    timeout_fail("wait_cnt");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      tick();
    end
    timeout_fail("wait_done");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Full run with step held high; start and step high together in IDLE.
    start = 1'b1; step = 1'b1; tick(); start = 1'b0;
    wait_done(); tick(); tick();

    // Stall for three cycles at cnt=4.
    start = 1'b1; tick(); start = 1'b0;
    wait_cnt(4); step = 1'b0; repeat (3) tick(); step = 1'b1;
    wait_done(); tick(); tick();

    // Reset mid-run at cnt=5, then restart.
    start = 1'b1; tick(); start = 1'b0;
    wait_cnt(5); reset = 1'b1; tick(); reset = 1'b0;
    repeat (2) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(); tick(); tick();

    // Start re-pulsed during RUN and DONE must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    wait_cnt(2); start = 1'b1; tick(); start = 1'b0;
    wait_done(); start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; step = 1'b0; tick(); start = 1'b0;
    repeat (3) tick(); step = 1'b1;
    wait_done(); tick(); tick();

    // Randomized start/step/reset traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom % 4) == 0;
      step  = ($urandom % 10) < 7;
      reset = ($urandom % 60) == 0;
      tick();
    end
    reset = 1'b0; start = 1'b0; step = 1'b1;
    repeat (15) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
